// File: rtl/muldiv_if.sv
// E-stage handshake between the pipeline and the multiply/divide unit.
// The pipeline side drives the op and operands; the unit returns HI/LO and Busy.
interface muldiv_if;
    logic [2:0]  MDOp;
    logic        IntReq;
    logic [31:0] D1;
    logic [31:0] D2;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;

    modport master (output MDOp, IntReq, D1, D2, input HI, LO, Busy);
    modport slave  (input MDOp, IntReq, D1, D2, output HI, LO, Busy);
endinterface

// File: rtl/muldiv_unit.sv
// Fixed-latency multiply/divide unit owning HI/LO for the 5-stage MIPS pipeline.
// The result is computed at launch, parked in hi_t/lo_t, and committed when the busy countdown expires.
module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        hi_t_q, hi_t_d, lo_t_q, lo_t_d;
    logic               wr_q, wr_d;

    logic               is_md;
    logic               start;
    logic signed [63:0] d1_x, d2_x;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic [63:0]        sdiv_res;
    logic [31:0]        udiv_q, udiv_r;

    // Signed divide: quotient truncates toward zero, remainder takes the dividend's sign.
    function automatic logic [63:0] sdiv(input logic signed [31:0] a, input logic signed [31:0] b);
        logic [31:0] ua, ub, uq, ur;
        ua = a[31] ? (~a + 32'd1) : a;
        ub = b[31] ? (~b + 32'd1) : b;
        uq = (ub != 32'd0) ? (ua / ub) : 32'd0;
        ur = (ub != 32'd0) ? (ua % ub) : 32'd0;
        return {(a[31] ? (~ur + 32'd1) : ur), ((a[31] ^ b[31]) ? (~uq + 32'd1) : uq)};
    endfunction

    assign is_md    = (bus.MDOp >= OP_MULT) && (bus.MDOp <= OP_DIVU);
    assign start    = is_md && !bus.IntReq && !busy_q;
    assign bus.Busy = busy_q | (is_md & !bus.IntReq);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

    assign d1_x     = {{32{bus.D1[31]}}, bus.D1};
    assign d2_x     = {{32{bus.D2[31]}}, bus.D2};
    assign prod_s   = d1_x * d2_x;
    assign prod_u   = {32'd0, bus.D1} * {32'd0, bus.D2};
    assign sdiv_res = sdiv(bus.D1, bus.D2);
    assign udiv_q   = (bus.D2 != 32'd0) ? (bus.D1 / bus.D2) : 32'd0;
    assign udiv_r   = (bus.D2 != 32'd0) ? (bus.D1 % bus.D2) : 32'd0;

    always_comb begin
        state_d = state_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        hi_t_d  = hi_t_q;
        lo_t_d  = lo_t_q;
        wr_d    = wr_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    busy_d  = 1'b1;
                    state_d = RUN;
                    wr_d    = 1'b1;
                    case (bus.MDOp)
                        OP_MULT:  {hi_t_d, lo_t_d} = prod_s;
                        OP_MULTU: {hi_t_d, lo_t_d} = prod_u;
                        OP_DIV:   {hi_t_d, lo_t_d} = sdiv_res;
                        default:  {hi_t_d, lo_t_d} = {udiv_r, udiv_q};
                    endcase
                    if (bus.MDOp == OP_MULT || bus.MDOp == OP_MULTU) begin
                        cnt_d = CNT_W'(MULT_CYCLES);
                    end else begin
                        cnt_d = CNT_W'(DIV_CYCLES);
                        // Divide by zero still occupies the unit but leaves HI/LO untouched.
                        wr_d  = (bus.D2 != 32'd0);
                    end
                end else if (!bus.IntReq && bus.MDOp == OP_MTHI) begin
                    hi_d = bus.D1;
                end else if (!bus.IntReq && bus.MDOp == OP_MTLO) begin
                    lo_d = bus.D1;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    if (wr_q) begin
                        hi_d = hi_t_q;
                        lo_d = lo_t_q;
                    end
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            hi_t_q  <= '0;
            lo_t_q  <= '0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            hi_t_q  <= hi_t_d;
            lo_t_q  <= lo_t_d;
            wr_q    <= wr_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed scenarios plus randomized ops against a behavioural HI/LO model.
module tb_muldiv_unit;
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] m_hi, m_lo;

    muldiv_if bus ();

    muldiv_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Architectural result of a MulDiv op; a zero divisor keeps the previous HI/LO.
    function automatic logic [63:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] hi_in, input logic [31:0] lo_in);
        int sa, sb, q, r;
        longint sp;
        longint unsigned up;
        sa = a;
        sb = b;
        case (op)
            3'd1: begin sp = longint'(sa) * longint'(sb); return sp; end
            3'd2: begin up = longint'({32'd0, a}) * longint'({32'd0, b}); return up; end
            3'd3: begin
                if (b == 32'd0) return {hi_in, lo_in};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            3'd4: begin
                if (b == 32'd0) return {hi_in, lo_in};
                return {a % b, a / b};
            end
            default: return {hi_in, lo_in};
        endcase
    endfunction

    function automatic int expected_cycles(input logic [2:0] op, input logic intr);
        if (intr) return 0;
        return (op <= 3'd2) ? MULT_CYCLES + 1 : DIV_CYCLES + 1;
    endfunction

    // Drives one MulDiv op and counts cycles with Busy high (launch cycle included).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic intr,
                          output int cyc, output logic early);
        logic [31:0] hi0, lo0;
        hi0 = bus.HI;
        lo0 = bus.LO;
        bus.MDOp = op;
        bus.D1 = a;
        bus.D2 = b;
        bus.IntReq = intr;
        #1;
        cyc = 0;
        early = 1'b0;
        while (bus.Busy === 1'b1 && cyc < 64) begin
            cyc++;
            if (bus.HI !== hi0 || bus.LO !== lo0) early = 1'b1;
            @(posedge clk);
            #1;
            bus.MDOp = 3'd0;
            bus.IntReq = 1'b0;
            #1;
        end
        if (cyc == 0) begin
            @(posedge clk);
            #1;
        end
        bus.MDOp = 3'd0;
        bus.IntReq = 1'b0;
        #1;
    endtask

    task automatic write_reg(input logic [2:0] op, input logic [31:0] v, input logic intr);
        bus.MDOp = op;
        bus.D1 = v;
        bus.D2 = $urandom;
        bus.IntReq = intr;
        @(posedge clk);
        #1;
        bus.MDOp = 3'd0;
        bus.IntReq = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        bus.MDOp = 3'd0;
        bus.IntReq = 1'b0;
        bus.D1 = '0;
        bus.D2 = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got HI=%h LO=%h Busy=%b, expected 0/0/0", bus.HI, bus.LO, bus.Busy);
        end
        reset = 1'b0;
        @(posedge clk);
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
    endtask

    task automatic test_mult_signed();
        int cyc;
        logic early;
        run_op(3'd1, 32'hFFFFFFFD, 32'd5, 1'b0, cyc, early);
        checks++;
        if (cyc !== 6 || early !== 1'b0) begin
            errors++;
            $display("FAIL mult_busy: got busy_cycles=%0d early=%b, expected 6/0", cyc, early);
        end
        checks++;
        if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFF1) begin
            errors++;
            $display("FAIL mult_result: got HI=%h LO=%h, expected ffffffff/fffffff1", bus.HI, bus.LO);
        end
        m_hi = 32'hFFFFFFFF;
        m_lo = 32'hFFFFFFF1;
    endtask

    task automatic test_multu_div();
        int cyc;
        logic early;
        run_op(3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, cyc, early);
        checks++;
        if (cyc !== 6 || bus.HI !== 32'h1 || bus.LO !== 32'hFFFFFFFE) begin
            errors++;
            $display("FAIL multu: got cyc=%0d HI=%h LO=%h, expected 6/00000001/fffffffe", cyc, bus.HI, bus.LO);
        end
        run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, cyc, early);
        checks++;
        if (cyc !== 11 || early !== 1'b0) begin
            errors++;
            $display("FAIL div_busy: got busy_cycles=%0d early=%b, expected 11/0", cyc, early);
        end
        checks++;
        if (bus.HI !== 32'hFFFFFFFF || bus.LO !== 32'hFFFFFFFD) begin
            errors++;
            $display("FAIL div_result: got HI=%h LO=%h, expected ffffffff/fffffffd", bus.HI, bus.LO);
        end
        m_hi = bus.HI;
        m_lo = bus.LO;
    endtask

    task automatic test_div_zero();
        int cyc;
        logic early;
        write_reg(3'd5, 32'h11, 1'b0);
        write_reg(3'd6, 32'h22, 1'b0);
        checks++;
        if (bus.HI !== 32'h11 || bus.LO !== 32'h22 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL mthi_mtlo: got HI=%h LO=%h Busy=%b, expected 11/22/0", bus.HI, bus.LO, bus.Busy);
        end
        run_op(3'd4, 32'd7, 32'd0, 1'b0, cyc, early);
        checks++;
        if (cyc !== 11 || bus.HI !== 32'h11 || bus.LO !== 32'h22) begin
            errors++;
            $display("FAIL divu_zero: got cyc=%0d HI=%h LO=%h, expected 11/11/22", cyc, bus.HI, bus.LO);
        end
        m_hi = 32'h11;
        m_lo = 32'h22;
    endtask

    task automatic test_ignore_during_run();
        int cyc;
        cyc = 0;
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: begin bus.MDOp = 3'd1; bus.D1 = 32'd3; bus.D2 = 32'd4; end
                1: begin bus.MDOp = 3'd5; bus.D1 = 32'hAAAA; end
                2: begin bus.MDOp = 3'd4; bus.D1 = 32'd9; bus.D2 = 32'd2; end
                default: bus.MDOp = 3'd0;
            endcase
            #1;
            if (bus.Busy === 1'b1) cyc++;
            @(posedge clk);
            #1;
            if (k == 1) begin
                checks++;
                if (bus.HI !== 32'h11 || bus.LO !== 32'h22) begin
                    errors++;
                    $display("FAIL mthi_in_run: got HI=%h LO=%h, expected 11/22", bus.HI, bus.LO);
                end
            end
        end
        while (bus.Busy === 1'b1 && cyc < 64) begin
            cyc++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (cyc !== 6 || bus.HI !== 32'd0 || bus.LO !== 32'd12) begin
            errors++;
            $display("FAIL ignore_in_run: got cyc=%0d HI=%h LO=%h, expected 6/0/c", cyc, bus.HI, bus.LO);
        end
        m_hi = 32'd0;
        m_lo = 32'd12;
    endtask

    task automatic test_intreq();
        bus.MDOp = 3'd1;
        bus.D1 = 32'd7;
        bus.D2 = 32'd9;
        bus.IntReq = 1'b1;
        #1;
        checks++;
        if (bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL intreq_busy: got Busy=%b, expected 0", bus.Busy);
        end
        @(posedge clk);
        #1;
        bus.MDOp = 3'd0;
        bus.IntReq = 1'b0;
        #1;
        checks++;
        if (bus.Busy !== 1'b0 || bus.HI !== m_hi || bus.LO !== m_lo) begin
            errors++;
            $display("FAIL intreq_mult: got Busy=%b HI=%h LO=%h, expected 0/%h/%h", bus.Busy, bus.HI, bus.LO, m_hi, m_lo);
        end
        write_reg(3'd6, 32'h1234, 1'b1);
        checks++;
        if (bus.LO !== m_lo) begin
            errors++;
            $display("FAIL intreq_mtlo: got LO=%h, expected %h", bus.LO, m_lo);
        end
        write_reg(3'd7, 32'h5678, 1'b0);
        checks++;
        if (bus.HI !== m_hi || bus.LO !== m_lo || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL reserved_op: got HI=%h LO=%h Busy=%b, expected %h/%h/0", bus.HI, bus.LO, bus.Busy, m_hi, m_lo);
        end
    endtask

    task automatic test_reset_mid_run();
        int cyc;
        logic early;
        bus.MDOp = 3'd3;
        bus.D1 = 32'd100;
        bus.D2 = 32'd7;
        @(posedge clk);
        #1;
        bus.MDOp = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.HI !== 32'd0 || bus.LO !== 32'd0 || bus.Busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_run: got HI=%h LO=%h Busy=%b, expected 0/0/0", bus.HI, bus.LO, bus.Busy);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_op(3'd2, 32'd6, 32'd7, 1'b0, cyc, early);
        checks++;
        if (cyc !== 6 || bus.HI !== 32'd0 || bus.LO !== 32'd42) begin
            errors++;
            $display("FAIL after_reset: got cyc=%0d HI=%h LO=%h, expected 6/0/2a", cyc, bus.HI, bus.LO);
        end
        m_hi = 32'd0;
        m_lo = 32'd42;
    endtask

    task automatic test_random();
        int cyc;
        logic early;
        logic [2:0] op;
        logic [31:0] a, b;
        logic intr;
        logic [63:0] exp;
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 50)));
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd3;
            intr = ($urandom_range(0, 5) == 0);
            if (op >= 3'd1 && op <= 3'd4) begin
                exp = intr ? {m_hi, m_lo} : ref_op(op, a, b, m_hi, m_lo);
                run_op(op, a, b, intr, cyc, early);
                checks++;
                if (cyc !== expected_cycles(op, intr) || early !== 1'b0) begin
                    errors++;
                    $display("FAIL rand_busy[%0d]: op=%0d int=%b got cyc=%0d early=%b, expected %0d/0",
                             n, op, intr, cyc, early, expected_cycles(op, intr));
                end
            end else begin
                exp = {m_hi, m_lo};
                if (!intr && op == 3'd5) exp[63:32] = a;
                if (!intr && op == 3'd6) exp[31:0] = a;
                write_reg(op, a, intr);
            end
            checks++;
            if (bus.HI !== exp[63:32] || bus.LO !== exp[31:0] || bus.Busy !== 1'b0) begin
                errors++;
                $display("FAIL rand_result[%0d]: op=%0d a=%h b=%h int=%b got HI=%h LO=%h Busy=%b, expected %h/%h/0",
                         n, op, a, b, intr, bus.HI, bus.LO, bus.Busy, exp[63:32], exp[31:0]);
            end
            m_hi = exp[63:32];
            m_lo = exp[31:0];
        end
    endtask

    initial begin
        test_reset();
        test_mult_signed();
        test_multu_div();
        test_div_zero();
        test_ignore_during_run();
        test_intreq();
        test_reset_mid_run();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
